// File: rtl/acdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acdc_pkg
// Purpose  : Shared constants, fetch FSM state type, branch-target table and
//            offset sign-extension helper for the ACDC fetch stage.
// Contents : PC_W, LUT_AW, OFF_W widths; fetch_state_t; BRANCH_LUT;
//            sext_offset().
// Revision : 1.0 - initial release
// ============================================================================
package acdc_pkg;

  localparam int PC_W   = 10;  // program counter width, imem depth 2**PC_W
  localparam int LUT_AW = 4;   // branch-target LUT index width
  localparam int OFF_W  = 6;   // signed relative-branch offset width

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // Absolute jump / LUT-branch targets. Programs retarget branches here only.
  localparam logic [PC_W-1:0] BRANCH_LUT [2**LUT_AW] = '{
    10'h000, 10'h014, 10'h12C, 10'h0A0,
    10'h200, 10'h140, 10'h3FF, 10'h050,
    10'h100, 10'h180, 10'h2A0, 10'h300,
    10'h07F, 10'h1E0, 10'h260, 10'h3C0
  };

  // Two's-complement widening of a relative displacement to PC width, so a
  // plain PC_W-bit add wraps modulo 2**PC_W in both directions.
  function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Control/flow bundle between the ACDC core and its fetch stage.
// Signals  : stall, branch_en, jump_en, rel_sel, target_idx, offset, halt_req
//            (core -> fetch); PC, halt, redirect (fetch -> core).
// Modports : master = core side, slave = fetch unit side.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import acdc_pkg::*;

  logic              stall;
  logic              branch_en;
  logic              jump_en;
  logic              rel_sel;
  logic [LUT_AW-1:0] target_idx;
  logic [OFF_W-1:0]  offset;
  logic              halt_req;
  logic [PC_W-1:0]   PC;
  logic              halt;
  logic              redirect;

  modport master (
    output stall, branch_en, jump_en, rel_sel, target_idx, offset, halt_req,
    input  PC, halt, redirect
  );

  modport slave (
    input  stall, branch_en, jump_en, rel_sel, target_idx, offset, halt_req,
    output PC, halt, redirect
  );

endinterface
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
// Module   : branch_lut
// Purpose  : Combinational ROM mapping a branch-target index to an absolute
//            instruction address; contents come from acdc_pkg::BRANCH_LUT.
// Ports    : idx    (in,  LUT_AW) table index
//            target (out, PC_W)   absolute target address
// Revision : 1.0 - initial release
// ============================================================================
module branch_lut
  import acdc_pkg::*;
(
  input  logic [LUT_AW-1:0] idx,
  output logic [PC_W-1:0]   target
);

  assign target = BRANCH_LUT[idx];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : ACDC instruction-fetch stage. Owns the program counter, resolves
//            sequential / LUT-jump / relative-branch next PC, and produces the
//            halt flag. All outputs are registered.
// Ports    : CLK   (in)  clock, rising edge
//            start (in)  synchronous active-high reset/init
//            bus   (fetch_unit_if.slave) core controls in; PC, halt,
//                  redirect out
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import acdc_pkg::*;
(
  input  logic         CLK,
  input  logic         start,
  fetch_unit_if.slave  bus
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic            r_halt;
  logic            w_halt_next;
  logic            r_redirect;
  logic            w_redirect_next;
  logic [PC_W-1:0] w_lut_target;
  logic [PC_W-1:0] w_rel_target;

  branch_lut u_branch_lut (
    .idx    (bus.target_idx),
    .target (w_lut_target)
  );

  // Width-matched add: overflow bits fall off, giving mod 2**PC_W wrap.
  assign w_rel_target = r_pc + sext_offset(bus.offset);

  // State register; start overrides everything else.
  always_ff @(posedge CLK) begin
    if (start) begin
      r_state    <= ST_RESET;
      r_pc       <= '0;
      r_halt     <= 1'b0;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_halt     <= w_halt_next;
      r_redirect <= w_redirect_next;
    end
  end

  // Next-state / next-PC. redirect is a one-cycle pulse, so it defaults low.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_halt_next     = r_halt;
    w_redirect_next = 1'b0;

    unique case (r_state)
      ST_RESET: begin
        // PC stays 0 so address 0 is the first instruction executed.
        w_pc_next    = '0;
        w_halt_next  = 1'b0;
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (bus.halt_req) begin
          w_state_next = ST_HALTED;
          w_halt_next  = 1'b1;
        end else if (bus.stall) begin
          w_pc_next = r_pc;
        end else if (bus.jump_en || (bus.branch_en && !bus.rel_sel)) begin
          // A jump wins over a simultaneous branch, so rel_sel is ignored.
          w_pc_next       = w_lut_target;
          w_redirect_next = 1'b1;
        end else if (bus.branch_en) begin
          // Zero offset is a legal self-loop and still flags a redirect.
          w_pc_next       = w_rel_target;
          w_redirect_next = 1'b1;
        end else begin
          w_pc_next = r_pc + PC_W'(1);
        end
      end

      ST_HALTED: begin
        w_halt_next = 1'b1;
      end

      default: begin
        w_state_next = ST_RESET;
        w_pc_next    = '0;
        w_halt_next  = 1'b0;
      end
    endcase
  end

  assign bus.PC       = r_pc;
  assign bus.halt     = r_halt;
  assign bus.redirect = r_redirect;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the ACDC core datapath.
- Owns the 10-bit program counter (PC) that addresses instruction memory; ACDC's control decodes the returned 9-bit instruction.
- Resolves the next PC from sequential increment, absolute jumps through a target lookup table, and signed relative branches.
- Generates the `halt` flag that ACDC exports and that freezes its cycle counter.

Parameters:
- PC_W, 10, program counter width; instruction memory depth is 2**PC_W.
- LUT_AW, 4, branch-target LUT index width (16 entries).
- OFF_W, 6, signed relative-branch offset width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- start  input  1  synchronous, active-high reset/init. Sampled only on the rising edge of CLK.
- stall  input  1  hold the PC this cycle (multi-cycle memory access in the core).
- branch_en  input  1  conditional branch taken (core flag already evaluated).
- jump_en  input  1  unconditional absolute jump.
- rel_sel  input  1  for a taken branch: 1 = relative offset, 0 = LUT target.
- target_idx  input  LUT_AW  index into the branch-target LUT.
- offset  input  OFF_W  signed two's-complement relative displacement.
- halt_req  input  1  halt instruction decoded by the core.
- PC  output  PC_W  current instruction address.
- halt  output  1  done flag; stays high until start.
- redirect  output  1  pulses for one cycle when the PC is loaded non-sequentially (observability).

Behaviour:
- Reset values (start = 1 at an edge):
  - PC = 0, halt = 0, redirect = 0, state = RESET.
  - Reset overrides every other input.
- FSM states: RESET, RUN, HALTED.
- RESET:
  - PC is held at 0.
  - At an edge with start = 0: go to RUN. PC stays 0, so the instruction at address 0 is executed first.
- RUN: next-PC priority at each edge, highest first:
  1. halt_req → state HALTED, halt = 1, PC unchanged.
  2. stall → PC unchanged, redirect = 0.
  3. jump_en → PC = LUT[target_idx], redirect = 1.
  4. branch_en with rel_sel = 0 → PC = LUT[target_idx], redirect = 1.
  5. branch_en with rel_sel = 1 → PC = (PC + sign_ext(offset)) mod 2**PC_W, redirect = 1.
  6. Otherwise → PC = (PC + 1) mod 2**PC_W, redirect = 0.
  - jump_en and branch_en together: treated as a jump (LUT target; rel_sel ignored).
- HALTED:
  - PC frozen, halt = 1, redirect = 0.
  - All inputs except start are ignored.
  - start = 1 → RESET.
- Latency: the new PC is visible one cycle after the control inputs are sampled; there is no combinational path from the inputs to PC.
- Wrap-around: sequential increment from 1023 goes to 0. Relative arithmetic wraps modulo 1024 in both directions. No flag is raised.
- Offset of 0 with a taken relative branch: PC unchanged, redirect = 1 (a self-loop is legal).
- start asserted mid-operation, including while stall or halt_req is active: the next edge resets per the reset values above.
- All outputs are registered.

Decomposition:
- Shared package acdc_pkg holds:
  - constants PC_W, LUT_AW, OFF_W;
  - the fetch FSM state enum (RESET, RUN, HALTED);
  - the 16-entry branch-target constant array.
- Sub-module branch_lut:
  - purely combinational ROM;
  - index LUT_AW bits in, PC_W-bit target out;
  - contents taken from acdc_pkg, so programs change targets in one place.

Test Plan:
- Reset release: start = 1 for 2 cycles, then 0 → PC = 0 in the first RUN cycle, then 1, 2, 3 on successive edges; halt = 0.
- Jump: LUT[3] = 10'h0A0; at PC = 5 pulse jump_en with target_idx = 3 → next PC = 0x0A0 and redirect = 1 for one cycle; the following PC is 0x0A1.
- Relative branch, backward and wrap: at PC = 2, branch_en = 1, rel_sel = 1, offset = 6'b111100 (−4) → PC = 1022. Then with no branches: 1023, then 0.
- Stall and priority: at PC = 7, assert stall for 3 cycles with branch_en high → PC stays 7 for 3 edges. After release, the branch taken on that edge redirects the PC.
- Halt: halt_req = 1 at PC = 20 → halt = 1 next cycle, PC stays 20 for 10 cycles despite jump_en and branch_en toggling. start = 1 → PC = 0, halt = 0.
- Reset mid-run: start asserted at PC = 300 while jump_en = 1 → next PC = 0 and redirect = 0; jump ignored.
